// File: rtl/cmac_div_pkg.sv
// Shared constants and FSM encoding for the CMAC 32/16 signed divider.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cmac_div_pkg;

    localparam int DIVIDEND_W = 32;
    localparam int DIVISOR_W  = 16;
    localparam int ITER_CNT   = 32;

    // Saturated quotient range: signed 16-bit, sign-extended to 32 bits.
    localparam logic [DIVIDEND_W-1:0] SAT_POS = 32'h0000_7FFF;
    localparam logic [DIVIDEND_W-1:0] SAT_NEG = 32'hFFFF_8000;

    // Divide-by-zero quotients for the full-width (non-saturating) build.
    localparam logic [DIVIDEND_W-1:0] DZ_POS = 32'h7FFF_FFFF;
    localparam logic [DIVIDEND_W-1:0] DZ_NEG = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/cmac_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, keep or restore.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module cmac_div_step (
    input  logic [16:0] rem_in,
    input  logic        dvd_bit,
    input  logic [15:0] dsor,
    output logic [16:0] rem_out,
    output logic        q_bit
);

    logic [17:0] shifted;
    logic [17:0] diff;

    // Trial subtraction carried one bit wide so the borrow shows the restore case.
    always_comb begin
        shifted = {rem_in, dvd_bit};
        diff    = shifted - {2'b00, dsor};
        q_bit   = ~diff[17];
        rem_out = q_bit ? diff[16:0] : shifted[16:0];
    end

endmodule

// File: rtl/cmac_div32x16.sv
// Sequential signed 32/16 restoring divider (C semantics); macro CMAC_DIV_SAT_EN clamps quotient to 16-bit.
// Latency: result 34 cycles after accept (2 for divide-by-zero); one operation in flight.
// Backpressure: in_prdy only in IDLE; result held in DONE until out_prdy.
module cmac_div32x16
    import cmac_div_pkg::*;
(
    input  logic                  nvdla_core_clk,
    input  logic                  nvdla_core_rstn,
    input  logic                  in_pvld,
    output logic                  in_prdy,
    input  logic [DIVIDEND_W-1:0] in_dividend,
    input  logic [DIVISOR_W-1:0]  in_divisor,
    output logic                  out_pvld,
    input  logic                  out_prdy,
    output logic [DIVIDEND_W-1:0] out_quot,
    output logic [DIVISOR_W-1:0]  out_rem,
    output logic                  out_dz,
    output logic                  out_ovf
);

    div_state_e state_q, state_nxt;

    logic                  alive_q;
    logic                  accept;
    logic [DIVIDEND_W-1:0] dvd_q;      // dividend magnitude, becomes quotient magnitude
    logic [DIVISOR_W-1:0]  dsor_q;     // divisor magnitude
    logic [16:0]           rem_q;      // partial remainder
    logic [4:0]            cnt_q;
    logic                  sign_q_q;
    logic                  sign_r_q;
    logic                  dz_q;

    logic [DIVIDEND_W-1:0] mag_dvd;
    logic [DIVISOR_W-1:0]  mag_dsor;
    logic [16:0]           rem_nxt;
    logic                  q_bit;

    logic [DIVIDEND_W-1:0] fix_quot;
    logic [DIVISOR_W-1:0]  fix_rem;
    logic                  fix_ovf;

    logic [DIVIDEND_W-1:0] quot_q;
    logic [DIVISOR_W-1:0]  rem_out_q;
    logic                  dz_out_q;
    logic                  ovf_out_q;

    // in_prdy stays low through reset and comes up one clock after release.
    assign in_prdy  = alive_q && (state_q == IDLE);
    assign accept   = in_pvld && in_prdy;
    assign out_pvld = (state_q == DONE);
    assign out_quot = quot_q;
    assign out_rem  = rem_out_q;
    assign out_dz   = dz_out_q;
    assign out_ovf  = ovf_out_q;

    // Operand magnitudes; the most negative values map to 2^31 / 2^15 as unsigned.
    assign mag_dvd  = in_dividend[DIVIDEND_W-1] ? (32'd0 - in_dividend) : in_dividend;
    assign mag_dsor = in_divisor[DIVISOR_W-1]   ? (16'd0 - in_divisor)  : in_divisor;

    cmac_div_step u_step (
        .rem_in  (rem_q),
        .dvd_bit (dvd_q[DIVIDEND_W-1]),
        .dsor    (dsor_q),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    // Sign fixup and optional saturation of the finished magnitudes.
    always_comb begin
        fix_quot = '0;
        fix_rem  = '0;
        fix_ovf  = 1'b0;
`ifdef CMAC_DIV_SAT_EN
        begin
            logic signed [32:0] q_sgn;
            q_sgn = sign_q_q ? -$signed({1'b0, dvd_q}) : $signed({1'b0, dvd_q});
            if (dz_q) begin
                fix_quot = sign_r_q ? SAT_NEG : SAT_POS;
                fix_ovf  = 1'b1;
            end else if (q_sgn > 33'sd32767) begin
                fix_quot = SAT_POS;
                fix_ovf  = 1'b1;
            end else if (q_sgn < -33'sd32768) begin
                fix_quot = SAT_NEG;
                fix_ovf  = 1'b1;
            end else begin
                fix_quot = q_sgn[31:0];
            end
        end
`else
        if (dz_q) begin
            fix_quot = sign_r_q ? DZ_NEG : DZ_POS;
        end else begin
            fix_quot = sign_q_q ? (32'd0 - dvd_q) : dvd_q;
        end
`endif
        if (!dz_q) begin
            fix_rem = sign_r_q ? (16'd0 - rem_q[15:0]) : rem_q[15:0];
        end
    end

    // FSM state register plus the post-reset ready enable.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q <= IDLE;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            alive_q <= 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: if (accept) state_nxt = (in_divisor == '0) ? FIX : CALC;
            CALC: if (cnt_q == 5'd0) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (out_prdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            dvd_q     <= '0;
            dsor_q    <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            sign_q_q  <= 1'b0;
            sign_r_q  <= 1'b0;
            dz_q      <= 1'b0;
            quot_q    <= '0;
            rem_out_q <= '0;
            dz_out_q  <= 1'b0;
            ovf_out_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        dvd_q    <= mag_dvd;
                        dsor_q   <= mag_dsor;
                        rem_q    <= '0;
                        cnt_q    <= 5'(ITER_CNT - 1);
                        sign_q_q <= in_dividend[DIVIDEND_W-1] ^ in_divisor[DIVISOR_W-1];
                        sign_r_q <= in_dividend[DIVIDEND_W-1];
                        dz_q     <= (in_divisor == '0);
                    end
                end
                CALC: begin
                    rem_q <= rem_nxt;
                    dvd_q <= {dvd_q[DIVIDEND_W-2:0], q_bit};
                    cnt_q <= cnt_q - 5'd1;
                end
                FIX: begin
                    quot_q    <= fix_quot;
                    rem_out_q <= fix_rem;
                    dz_out_q  <= dz_q;
                    ovf_out_q <= fix_ovf;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cmac_div32x16.sv
// Directed self-checking bench for cmac_div32x16 with hand-computed vectors.
// Latency: checks 34-cycle normal and 2-cycle divide-by-zero result timing.
// Backpressure: exercises result hold under out_prdy=0 and reset mid-calculation.
module tb_cmac_div32x16;

`ifdef CMAC_DIV_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic        nvdla_core_clk = 1'b0;
    logic        nvdla_core_rstn = 1'b0;
    logic        in_pvld = 1'b0;
    logic        in_prdy;
    logic [31:0] in_dividend = '0;
    logic [15:0] in_divisor = '0;
    logic        out_pvld;
    logic        out_prdy = 1'b0;
    logic [31:0] out_quot;
    logic [15:0] out_rem;
    logic        out_dz;
    logic        out_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 nvdla_core_clk = ~nvdla_core_clk;

    cmac_div32x16 dut (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .in_pvld         (in_pvld),
        .in_prdy         (in_prdy),
        .in_dividend     (in_dividend),
        .in_divisor      (in_divisor),
        .out_pvld        (out_pvld),
        .out_prdy        (out_prdy),
        .out_quot        (out_quot),
        .out_rem         (out_rem),
        .out_dz          (out_dz),
        .out_ovf         (out_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present operands at a falling edge once the block is ready; return after the accepting edge.
    task automatic send(input string tag, input logic [31:0] a, input logic [15:0] b);
        int w;
        w = 0;
        @(negedge nvdla_core_clk);
        while (!in_prdy && w < 50) begin
            @(negedge nvdla_core_clk);
            w++;
        end
        if (!in_prdy) check({tag, ".ready_timeout"}, 32'(in_prdy), 32'd1);
        in_pvld     = 1'b1;
        in_dividend = a;
        in_divisor  = b;
        @(posedge nvdla_core_clk);
        #1;
        // Garbage while busy must not disturb the captured operands.
        in_pvld     = 1'b0;
        in_dividend = 32'hDEAD_BEEF;
        in_divisor  = 16'h0003;
    endtask

    // Count falling edges after acceptance until out_pvld is seen.
    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(negedge nvdla_core_clk);
            lat++;
        end while (!out_pvld && lat < 100);
    endtask

    task automatic consume(input string tag);
        out_prdy = 1'b1;
        @(posedge nvdla_core_clk);
        #1;
        out_prdy = 1'b0;
        @(negedge nvdla_core_clk);
        check({tag, ".idle_prdy"}, 32'(in_prdy), 32'd1);
        check({tag, ".pvld_drop"}, 32'(out_pvld), 32'd0);
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [15:0] b,
                         input logic [31:0] eq, input logic [15:0] er,
                         input logic edz, input logic eovf, input int elat);
        int lat;
        send(tag, a, b);
        wait_result(lat);
        check({tag, ".lat"},  32'(lat),      32'(elat));
        check({tag, ".quot"}, out_quot,      eq);
        check({tag, ".rem"},  32'(out_rem),  32'(er));
        check({tag, ".dz"},   32'(out_dz),   32'(edz));
        check({tag, ".ovf"},  32'(out_ovf),  32'(eovf));
        consume(tag);
    endtask

    initial begin : main
        int lat;
        logic [31:0] q0;
        logic [15:0] r0;
        bit stable;

        // Reset state.
        repeat (3) @(negedge nvdla_core_clk);
        check("rst.prdy", 32'(in_prdy),  32'd0);
        check("rst.pvld", 32'(out_pvld), 32'd0);
        check("rst.quot", out_quot,      32'd0);
        check("rst.rem",  32'(out_rem),  32'd0);
        check("rst.dz",   32'(out_dz),   32'd0);
        check("rst.ovf",  32'(out_ovf),  32'd0);
        nvdla_core_rstn = 1'b1;
        @(negedge nvdla_core_clk);
        check("rel.prdy", 32'(in_prdy), 32'd1);

        do_op("p100d7",   32'd100,          16'd7,      32'h0000_000E, 16'h0002, 1'b0, 1'b0, 34);
        do_op("n100d7",   -32'sd100,        16'd7,      32'hFFFF_FFF2, 16'hFFFE, 1'b0, 1'b0, 34);
        do_op("p100dn7",  32'd100,          16'hFFF9,   32'hFFFF_FFF2, 16'h0002, 1'b0, 1'b0, 34);
        do_op("n7d100",   32'hFFFF_FFF9,    16'd100,    32'h0000_0000, 16'hFFF9, 1'b0, 1'b0, 34);
        do_op("prod_rt",  32'h3FFF_0001,    16'h7FFF,   32'h0000_7FFF, 16'h0000, 1'b0, 1'b0, 34);
        do_op("prod_neg", 32'h4000_0000,    16'h8000,   32'hFFFF_8000, 16'h0000, 1'b0, 1'b0, 34);
        do_op("dz_pos",   32'h0000_1234,    16'h0000,
              SAT_EN ? 32'h0000_7FFF : 32'h7FFF_FFFF, 16'h0000, 1'b1, SAT_EN, 2);
        do_op("dz_neg",   32'h8000_0000,    16'h0000,
              SAT_EN ? 32'hFFFF_8000 : 32'h8000_0000, 16'h0000, 1'b1, SAT_EN, 2);
        do_op("min_dm1",  32'h8000_0000,    16'hFFFF,
              SAT_EN ? 32'h0000_7FFF : 32'h8000_0000, 16'h0000, 1'b0, SAT_EN, 34);
        do_op("1e6d3",    32'd1000000,      16'd3,
              SAT_EN ? 32'h0000_7FFF : 32'h0005_1615, 16'h0001, 1'b0, SAT_EN, 34);

        // Hold the result under backpressure for 10 cycles.
        send("hold", 32'd100, 16'd7);
        wait_result(lat);
        check("hold.lat", 32'(lat), 32'd34);
        q0 = out_quot;
        r0 = out_rem;
        stable = 1'b1;
        repeat (10) begin
            @(negedge nvdla_core_clk);
            if (!out_pvld || in_prdy || out_quot !== q0 || out_rem !== r0) stable = 1'b0;
        end
        check("hold.stable", 32'(stable), 32'd1);
        check("hold.quot",   out_quot,    32'h0000_000E);
        consume("hold");

        // Reset in the middle of CALC aborts the operation.
        send("abort", 32'd100, 16'd7);
        repeat (10) @(negedge nvdla_core_clk);
        check("abort.busy", 32'(in_prdy), 32'd0);
        nvdla_core_rstn = 1'b0;
        #1;
        check("abort.pvld_rst", 32'(out_pvld), 32'd0);
        check("abort.prdy_rst", 32'(in_prdy),  32'd0);
        @(negedge nvdla_core_clk);
        nvdla_core_rstn = 1'b1;
        @(negedge nvdla_core_clk);
        check("abort.prdy_rel", 32'(in_prdy),  32'd1);
        check("abort.pvld_rel", 32'(out_pvld), 32'd0);
        repeat (40) @(negedge nvdla_core_clk);
        check("abort.no_result", 32'(out_pvld), 32'd0);

        // Block still works after the abort.
        do_op("post_rst", 32'd100, 16'd7, 32'h0000_000E, 16'h0002, 1'b0, 1'b0, 34);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cmac_div32x16.md
# cmac_div32x16

Sequential signed divider that inverts the CMAC 16x16 product path. It takes a 32-bit two's-complement dividend, such as a stored 16x16 MAC product, and a 16-bit signed divisor. It returns quotient, remainder and status after a fixed multi-cycle restoring-division sequence. It sits beside the CMAC multiplier array for rescale and normalisation paths, with pvld/prdy handshakes on both sides.

## Interface
- DIVIDEND_W, 32, dividend and quotient width (fixed; other values unsupported)
- DIVISOR_W, 16, divisor and remainder width (fixed)
- nvdla_core_clk  input  1  core clock, rising edge
- nvdla_core_rstn  input  1  reset, asynchronous, active-low
- in_pvld  input  1  operand valid
- in_prdy  output  1  block can accept operands
- in_dividend  input  32  signed dividend
- in_divisor  input  16  signed divisor
- out_pvld  output  1  result valid
- out_prdy  input  1  consumer accepts result
- out_quot  output  32  signed quotient
- out_rem  output  16  signed remainder
- out_dz  output  1  divide-by-zero flag
- out_ovf  output  1  quotient overflow or saturation flag

## Operation
- FSM states: IDLE, CALC, FIX, DONE. Reset state is IDLE.
- IDLE:
  - in_prdy=1.
  - On in_pvld&in_prdy, capture operands.
  - Form magnitudes: |dividend| as 32-bit unsigned (0x80000000 maps to 2^31), |divisor| as 16-bit unsigned (0x8000 maps to 32768).
  - Record sign_q = sign(dividend)^sign(divisor) and sign_r = sign(dividend).
  - If divisor==0, go to FIX with dz=1. Otherwise load iteration counter=31 and go to CALC.
- CALC:
  - One restoring step per cycle on a 17-bit partial remainder: shift in the next dividend MSB, trial-subtract the divisor, and keep or restore. The quotient bit shifts in.
  - Go to FIX after the counter reaches 0 (32 steps).
- FIX:
  - Negate the quotient if sign_q. Negate the remainder if sign_r.
  - Semantics match C: truncation toward zero, and the remainder takes the dividend's sign.
  - Divide-by-zero result: quot = dividend≥0 ? 0x7FFFFFFF : 0x80000000, rem = 0, dz = 1.
  - Go to DONE.
- DONE:
  - out_pvld=1. Outputs are held stable until out_prdy=1, then the FSM returns to IDLE.
  - in_prdy=0 in every state other than IDLE.
- Operand inputs are ignored while busy. Only values captured at acceptance matter.
- Quotient 0x80000000 / −1: true magnitude is 2^31.
  - Without saturation: quot wraps to 0x80000000, ovf=0.
  - With saturation: see Configuration.
- A zero result is always encoded as 0x00000000 or 0x0000. No negative zero.

## Timing
- Reset values: in_prdy=0 while nvdla_core_rstn is low and 1 from the first clock after release. out_pvld=0, out_quot=0, out_rem=0, out_dz=0, out_ovf=0.
- Normal latency: accept at edge T, CALC covers T+1..T+32, FIX at T+33, out_pvld rises at T+34.
- Divide-by-zero latency: out_pvld rises at T+2.
- Result accept at edge U (out_pvld&out_prdy) puts the FSM in IDLE at U+1, with in_prdy=1 in that cycle.
- Best throughput is one operation per 35 cycles.
- Reset asserted mid-operation aborts immediately: all state clears and no result is produced.

## Configuration
- Macro CMAC_DIV_SAT_EN.
- Defined: the quotient saturates to the signed 16-bit range.
  - quot > 32767 → 0x00007FFF with ovf=1.
  - quot < −32768 → 0xFFFF8000 with ovf=1.
  - Divide-by-zero gives 0x00007FFF or 0xFFFF8000, with dz=1 and ovf=1.
- Undefined: the full 32-bit quotient is output and ovf is tied 0.

## Structure
- Shared package cmac_div_pkg holds:
  - FSM state encoding
  - DIVIDEND_W and DIVISOR_W
  - iteration count 32
  - saturation constants 0x7FFF and −0x8000
  - divide-by-zero quotient constants
- Sub-module cmac_div_step: combinational single restoring iteration. Inputs are the partial remainder, the next dividend bit and the divisor magnitude. Outputs are the next partial remainder and the quotient bit.
- FSM, counter, sign fixup and output registers live in the top module.

## Test plan
- 100 / 7 → quot 0x0000000E, rem 0x0002, dz=0, ovf=0; out_pvld exactly 34 cycles after acceptance.
- −100 / 7 → quot 0xFFFFFFF2, rem 0xFFFE; and 100 / −7 → quot 0xFFFFFFF2, rem 0x0002.
- Product round-trip: 0x3FFF0001 (32767×32767) / 0x7FFF → quot 0x00007FFF, rem 0; also 0x40000000 / 0x8000 → quot 0xFFFF8000, rem 0.
- 0x00001234 / 0 → out_pvld at T+2, dz=1, quot 0x7FFFFFFF (0x00007FFF with CMAC_DIV_SAT_EN, ovf=1), rem 0.
- 0x80000000 / 0xFFFF:
  - Without macro: quot 0x80000000, ovf=0.
  - With macro: quot 0x00007FFF, ovf=1.
  - With macro, 1000000 / 3 → 0x00007FFF, ovf=1.
- Hold out_prdy=0 for 10 cycles in DONE → outputs stable and in_prdy=0; assert nvdla_core_rstn low mid-CALC → out_pvld=0 and in_prdy=1 one clock after release.
